// File: rtl/dvs_ravens_pkg.sv
// Shared types and constants for the DVS-to-Ravens event path.
package dvs_ravens_pkg;

  localparam int EVENT_BITS        = 16;
  localparam int EVENT_QUEUE_DEPTH = 12;
  localparam int DROP_CNT_BITS     = 16;

  typedef logic [EVENT_BITS-1:0]                event_t;
  typedef logic [$clog2(EVENT_QUEUE_DEPTH)-1:0] event_addr_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } queue_op_e;

endpackage

// File: rtl/event_queue_ptr.sv
// Wrapping SRAM pointer for the event queue; DEPTH need not be a power of two.
module event_queue_ptr
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH = EVENT_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // Pointer register: steps by one and wraps from DEPTH-1 back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= {AW{1'b0}};
    end else if (advance) begin
      ptr <= (ptr == LAST) ? {AW{1'b0}} : ptr + AW'(1'b1);
    end
  end

endmodule

// File: rtl/event_queue_ctrl.sv
// FIFO controller arbitrating one single-port event SRAM between producer and consumer.
// Optional drop counter is enabled by defining EVENT_QUEUE_DROP_CNT_EN.
module event_queue_ctrl
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH = EVENT_QUEUE_DEPTH,
  parameter int WIDTH = EVENT_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_event,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_event,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [WIDTH-1:0]         sram_d_in,
  output logic                     sram_wr_en,
  output logic                     sram_sense_en,
  input  logic [WIDTH-1:0]         sram_d_out
`ifdef EVENT_QUEUE_DROP_CNT_EN
 ,output logic [DROP_CNT_BITS-1:0] drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  queue_op_e     last_op;
  logic          wr_req;
  logic          rd_req;
  logic          wr_gnt;
  logic          rd_gnt;
  logic          conflict;

  assign wr_req = in_valid && (count != FULL_COUNT);
  assign rd_req = (count != {CW{1'b0}}) && (!out_valid || out_ready);

  // Grant at most one SRAM access; a conflict goes to the opposite of the last winner.
  always_comb begin
    wr_gnt   = 1'b0;
    rd_gnt   = 1'b0;
    conflict = 1'b0;
    if (wr_req && rd_req) begin
      conflict = 1'b1;
      if (last_op == OP_READ) begin
        wr_gnt = 1'b1;
      end else begin
        rd_gnt = 1'b1;
      end
    end else if (wr_req) begin
      wr_gnt = 1'b1;
    end else if (rd_req) begin
      rd_gnt = 1'b1;
    end else begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
    end
  end

  event_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (wr_gnt),
    .ptr     (wr_ptr)
  );

  event_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (rd_gnt),
    .ptr     (rd_ptr)
  );

  // Strobes are gated by rst_n so the SRAM sees no access while reset is held.
  assign in_ready      = wr_gnt;
  assign sram_wr_en    = wr_gnt & rst_n;
  assign sram_sense_en = rd_gnt & rst_n;
  assign sram_addr     = wr_gnt ? wr_ptr : rd_ptr;
  assign sram_d_in     = in_event;
  assign out_event     = sram_d_out;
  assign level         = count;

  // Occupancy, presented-event flag and conflict history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= {CW{1'b0}};
      out_valid <= 1'b0;
      last_op   <= OP_READ;
    end else begin
      if (wr_gnt) begin
        count <= count + CW'(1'b1);
      end else if (rd_gnt) begin
        count <= count - CW'(1'b1);
      end
      out_valid <= rd_gnt || (out_valid && !out_ready);
      if (conflict) begin
        last_op <= wr_gnt ? OP_WRITE : OP_READ;
      end
    end
  end

`ifdef EVENT_QUEUE_DROP_CNT_EN
  localparam logic [DROP_CNT_BITS-1:0] DROP_MAX = {DROP_CNT_BITS{1'b1}};

  // Saturating count of cycles where upstream offered an event into a full queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= {DROP_CNT_BITS{1'b0}};
    end else if (in_valid && (count == FULL_COUNT) && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + DROP_CNT_BITS'(1'b1);
    end
  end
`endif

endmodule

// File: tb/tb_event_queue_ctrl.sv
// Self-checking bench for event_queue_ctrl with a behavioural SRAM and queue reference model.
module tb_event_queue_ctrl;
  import dvs_ravens_pkg::*;

  localparam int DEPTH = EVENT_QUEUE_DEPTH;
  localparam int W     = EVENT_BITS;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [W-1:0]    in_event;
  logic            in_ready;
  logic            out_valid;
  logic [W-1:0]    out_event;
  logic            out_ready;
  logic [AW:0]     level;
  logic [AW-1:0]   sram_addr;
  logic [W-1:0]    sram_d_in;
  logic            sram_wr_en;
  logic            sram_sense_en;
  logic [W-1:0]    sram_d_out = '0;
`ifdef EVENT_QUEUE_DROP_CNT_EN
  logic [DROP_CNT_BITS-1:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  event_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_event      (in_event),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_event     (out_event),
    .out_ready     (out_ready),
    .level         (level),
    .sram_addr     (sram_addr),
    .sram_d_in     (sram_d_in),
    .sram_wr_en    (sram_wr_en),
    .sram_sense_en (sram_sense_en),
    .sram_d_out    (sram_d_out)
`ifdef EVENT_QUEUE_DROP_CNT_EN
   ,.drop_cnt      (drop_cnt)
`endif
  );

  // Behavioural single-port SRAM: registered read data, held between reads.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_wr_en) mem[sram_addr] <= sram_d_in;
    if (sram_sense_en) sram_d_out <= mem[sram_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored events, presented event, and whose turn a conflict is.
  logic [W-1:0] mq[$];
  bit           m_pv;
  logic [W-1:0] m_pval;
  bit           m_wturn;
  bit           m_wr;
  bit           m_rd;
`ifdef EVENT_QUEUE_DROP_CNT_EN
  int           m_drop;
`endif

  task automatic model_reset();
    mq.delete();
    m_pv    = 1'b0;
    m_pval  = '0;
    m_wturn = 1'b1;
`ifdef EVENT_QUEUE_DROP_CNT_EN
    m_drop  = 0;
`endif
  endtask

  // Called at posedge+1: drive inputs, predict the grant, compare at the falling edge.
  task automatic drive_check(input bit iv, input logic [W-1:0] ev, input bit ordy);
    bit can_w;
    bit can_r;
    in_valid  = iv;
    in_event  = ev;
    out_ready = ordy;
    can_w = iv && (mq.size() < DEPTH);
    can_r = (mq.size() > 0) && (!m_pv || ordy);
    if (can_w && can_r) begin
      m_wr = m_wturn;
      m_rd = !m_wturn;
    end else begin
      m_wr = can_w;
      m_rd = can_r;
    end
    #4;
    chk("in_ready", in_ready, m_wr);
    chk("wr_en", sram_wr_en, m_wr);
    chk("sense_en", sram_sense_en, m_rd);
    chk("out_valid", out_valid, m_pv);
    chk("level", level, mq.size());
    if (m_pv) chk("out_event", out_event, m_pval);
    if (m_wr) chk("d_in", sram_d_in, ev);
`ifdef EVENT_QUEUE_DROP_CNT_EN
    chk("drop_model", drop_cnt, m_drop);
`endif
  endtask

  task automatic advance();
    bit conflict;
    conflict = in_valid && (mq.size() < DEPTH) && (mq.size() > 0) && (!m_pv || out_ready);
`ifdef EVENT_QUEUE_DROP_CNT_EN
    if (in_valid && mq.size() == DEPTH && m_drop < 65535) m_drop++;
`endif
    if (conflict) m_wturn = !m_wr;
    if (m_wr) mq.push_back(in_event);
    if (m_rd) begin
      m_pval = mq.pop_front();
      m_pv   = 1'b1;
    end else if (m_pv && out_ready) begin
      m_pv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit iv, input logic [W-1:0] ev, input bit ordy);
    drive_check(iv, ev, ordy);
    advance();
  endtask

  // Asserts reset with in_valid high; strobes must drop at once. Returns at posedge+1.
  task automatic do_reset();
    in_valid  = 1'b1;
    in_event  = W'(16'h5A5A);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_wr_en", sram_wr_en, 1'b0);
    chk("rst_sense_en", sram_sense_en, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Writes ascending events with out_ready low until the DUT stops accepting.
  task automatic fill_full(output int accepted);
    accepted = 0;
    for (int c = 0; c < 3 * DEPTH && accepted < DEPTH + 1; c++) begin
      drive_check(1'b1, W'(accepted + 1), 1'b0);
      if (in_ready) accepted++;
      advance();
    end
  endtask

  typedef struct {
    bit           iv;
    logic [W-1:0] ev;
    bit           ordy;
    bit           e_rdy;
    bit           e_wr;
    bit           e_rd;
    bit           e_ov;
    int           e_lvl;
    bit           chk_ev;
    logic [W-1:0] e_ev;
  } vec_t;

  vec_t vt[4];
  int   accepted;
  int   exp_ev;
  bit   prev_wr;
  logic [W-1:0] held;
  bit   pat[4];
  bit   seen;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_event = '0;
    out_ready = 1'b0;
    model_reset();

    // Single event through an empty queue: accept, read, present, consume.
    vt[0] = '{1'b1, W'(16'h002A), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, W'(16'h0)};
    vt[1] = '{1'b0, W'(16'h0000), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, W'(16'h0)};
    vt[2] = '{1'b0, W'(16'h0000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, W'(16'h002A)};
    vt[3] = '{1'b0, W'(16'h0000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, W'(16'h0)};

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_check(vt[i].iv, vt[i].ev, vt[i].ordy);
      chk("tbl_in_ready", in_ready, vt[i].e_rdy);
      chk("tbl_wr_en", sram_wr_en, vt[i].e_wr);
      chk("tbl_sense_en", sram_sense_en, vt[i].e_rd);
      chk("tbl_out_valid", out_valid, vt[i].e_ov);
      chk("tbl_level", level, vt[i].e_lvl);
      if (vt[i].chk_ev) chk("tbl_out_event", out_event, vt[i].e_ev);
      advance();
    end

    // Fill past DEPTH with consumer stalled, then drain across the pointer wrap.
    do_reset();
    fill_full(accepted);
    chk("fill_accepted", accepted, DEPTH + 1);
    drive_check(1'b1, W'(16'h7777), 1'b0);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_level", level, DEPTH);
    advance();
    exp_ev = 1;
    for (int c = 0; c < 4 * DEPTH && exp_ev <= DEPTH + 1; c++) begin
      drive_check(1'b0, '0, 1'b1);
      if (out_valid) begin
        chk("drain_order", out_event, exp_ev);
        exp_ev++;
      end
      advance();
    end
    chk("drain_count", exp_ev, DEPTH + 2);

    // Continuous contention after a short prefill: strict alternation, write first.
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, W'(16'h0100 + c), 1'b0);
    prev_wr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_check(1'b1, W'(16'h0200 + c), 1'b1);
      if (c == 0) chk("contend_first_write", sram_wr_en, 1'b1);
      else chk("contend_alternate", sram_wr_en, !prev_wr);
      chk("contend_one_op", sram_wr_en ^ sram_sense_en, 1'b1);
      prev_wr = sram_wr_en;
      advance();
    end

    // Backpressure: out_event must hold through a two-cycle stall.
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    held = '0;
    for (int k = 0; k < 4; k++) begin
      drive_check(1'b0, '0, pat[k]);
      chk("stall_valid", out_valid, 1'b1);
      if (k == 1) held = out_event;
      if (k == 2) chk("stall_hold", out_event, held);
      advance();
    end

    // Reset mid-stream with five stored events, then check ordering restarts cleanly.
    do_reset();
    for (int c = 0; c < 20 && level != 5; c++) step(1'b1, W'(16'h0300 + c), 1'b0);
    chk("pre_reset_level", level, 5);
    chk("pre_reset_valid", out_valid, 1'b1);
    do_reset();
    step(1'b1, W'(16'hBEEF), 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      drive_check(1'b0, '0, 1'b1);
      if (out_valid) begin
        chk("post_reset_event", out_event, W'(16'hBEEF));
        seen = 1'b1;
      end
      advance();
    end
    chk("post_reset_seen", seen, 1'b1);

`ifdef EVENT_QUEUE_DROP_CNT_EN
    // Seven offered events while full.
    do_reset();
    fill_full(accepted);
    for (int c = 0; c < 7; c++) step(1'b1, W'(16'h0400 + c), 1'b0);
    chk("drop_cnt", drop_cnt, 7);
`endif

    // Randomised traffic against the model: balanced, then consumer-starved.
    do_reset();
    for (int c = 0; c < 400; c++)
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0);
    for (int c = 0; c < 200; c++)
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 5) == 0);
    for (int c = 0; c < 60; c++)
      step(1'b0, '0, 1'b1);
    chk("final_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_queue_ctrl.md
# event_queue_ctrl

Single-clock FIFO controller for the DVS event queue. It takes camera events from the upstream capture stage over a valid/ready handshake and stores them in the single-port event SRAM (dummy_sram). It reads them back in order and presents them to the Ravens-side consumer over a second valid/ready handshake. Because the SRAM does one access per cycle, the block arbitrates writes against reads.

## Interface
- DEPTH, default EVENT_QUEUE_DEPTH: number of SRAM words; need not be a power of two.
- WIDTH, default EVENT_BITS: event width in bits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream event available.
- in_event  in  WIDTH  upstream event.
- in_ready  out  1  the event is accepted this cycle when in_valid && in_ready.
- out_valid  out  1  out_event holds the head event.
- out_event  out  WIDTH  head event, wired directly from sram_d_out; undefined while out_valid=0.
- out_ready  in  1  consumer takes the head when out_valid && out_ready.
- level  out  $clog2(DEPTH)+1  events stored in SRAM, excluding the one presented on out_*.
- sram_addr  out  $clog2(DEPTH)  SRAM address.
- sram_d_in  out  WIDTH  SRAM write data; equals in_event.
- sram_wr_en  out  1  SRAM write strobe.
- sram_sense_en  out  1  SRAM read strobe.
- sram_d_out  in  WIDTH  SRAM read data; registered, valid the cycle after sense_en, then held.
- drop_cnt  out  16  rejected-attempt counter; present only under EVENT_QUEUE_DROP_CNT_EN.

## Operation
- State held in flops:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits.
  - count, registered, drives level.
  - out_valid, registered.
  - last_op: 0 = read, 1 = write.
- Request signals:
  - wr_req = in_valid && count != DEPTH.
  - rd_req = count != 0 && (!out_valid || out_ready).
- Arbitration, at most one SRAM operation per cycle:
  - If only one request is active, it wins.
  - If both are active, the operation opposite to last_op wins.
  - last_op updates only on cycles where a conflict was resolved.
- in_ready = wr_req granted, so it depends combinationally on in_valid, out_ready and state.
  - Upstream must not make in_valid depend on in_ready.
- Write grant: sram_wr_en=1, sram_addr=wr_ptr, wr_ptr advances.
- Read grant: sram_sense_en=1, sram_addr=rd_ptr, rd_ptr advances.
- With no grant, sram_addr=rd_ptr and both strobes are 0.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0.
- count: +1 on write grant, -1 on read grant. Never both in one cycle, so count stays within 0..DEPTH.
- out_valid next = read grant || (out_valid && !out_ready).
  - The SRAM holds d_out between reads, so no output register is needed.
- Full (count==DEPTH): in_ready=0.
- Empty (count==0): no read is issued, even if a write is granted in the same cycle.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, last_op=0 (write wins the first conflict), drop_cnt=0.
- Reset effect on outputs: while rst_n=0 both SRAM strobes are forced to 0.
- Reset mid-operation discards all queued events and the presented event. The SRAM contents are not cleared.

## Timing
- Input to output latency into an empty queue:
  - Event accepted at edge N.
  - Read issued in cycle N+1.
  - out_valid=1 after edge N+2.
- Read-only throughput: 1 event/cycle while out_ready stays 1.
- Write-only throughput: 1 event/cycle until full.
- Under continuous contention: writes and reads alternate, each at 0.5 event/cycle.
- out_event changes only on the edge following a read grant.
- out_event is stable while out_valid && !out_ready.

## Configuration
- EVENT_QUEUE_DROP_CNT_EN defined:
  - drop_cnt increments on every cycle with in_valid && count==DEPTH.
  - It saturates at 16'hFFFF and clears only on reset.
- EVENT_QUEUE_DROP_CNT_EN undefined: the drop_cnt port and counter logic are absent; all other behaviour is identical.

## Structure
- Add to dvs_ravens_pkg:
  - typedef event_t (logic [EVENT_BITS-1:0]).
  - typedef event_addr_t (logic [$clog2(EVENT_QUEUE_DEPTH)-1:0]).
  - Constant DROP_CNT_BITS=16.
  - EVENT_BITS and EVENT_QUEUE_DEPTH already live there.
- One sub-module, event_queue_ptr: a wrapping pointer with advance input, parameterised on DEPTH, instantiated for wr_ptr and rd_ptr.
- The SRAM is instantiated outside this block, in the queue top.

## Test plan
- Reset, then 1 write of 0x2A with out_ready=1:
  - in_ready=1 at cycle 0.
  - sram_sense_en at cycle 1.
  - out_valid=1 with out_event=0x2A at cycle 2.
  - level returns to 0.
- Fill with out_ready=0:
  - Accept events 1..DEPTH+1 in order; the first is read into out_* first, so DEPTH+1 writes are accepted.
  - Then level=DEPTH and in_ready=0.
  - Drain with out_ready=1: events 1..DEPTH+1 appear in order, across the wr_ptr/rd_ptr wrap.
- Contention, in_valid=1 and out_ready=1 continuously after prefill of 3:
  - sram_wr_en and sram_sense_en alternate each cycle.
  - The first conflict grants the write.
- Backpressure: toggle out_ready 1,0,0,1 while out_valid=1 -> out_event holds its value through the stall and no event is lost or duplicated.
- Reset asserted mid-stream with level=5 -> out_valid, level and both strobes are 0 immediately; after release the next event written is the next event read.
- With EVENT_QUEUE_DROP_CNT_EN: hold in_valid=1 for 7 cycles while full -> drop_cnt=7.
